gather_rmw_ctrl: RTL and testbench

Read-modify-write controller that sequences one single-clock URAM vertex bank (1-cycle registered read, separate read/write address, `En`-gated) during the gather phase. It accepts a stream of vertex updates, combines each with the stored value (add or min), and writes the result back at full throughput, with hazard forwarding for back-to-back updates to the same vertex. It also arbitrates a host read/write port against the update stream and runs a bank-clear sweep between iterations.

---
 rtl/gather_rmw_ctrl_pkg.sv | 19 +
 rtl/gather_rmw_ctrl_rmw_fwd_stage.sv | 61 ++++++
 rtl/gather_rmw_ctrl.sv | 118 +++++++++++
 tb/tb_gather_rmw_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gather_rmw_ctrl_pkg.sv
// gather_rmw_ctrl_pkg -- shared op codes, top FSM state type and combine identity.
// Rev 1.0
`default_nettype none
package gather_rmw_ctrl_pkg;
  localparam int OP_ADD = 0;
  localparam int OP_MIN = 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Callers truncate to their data width; supports DATA_W up to 64.
  function automatic logic [63:0] identity_val(input int op);
    return (op == OP_MIN) ? {64{1'b1}} : 64'd0;
  endfunction
endpackage
`default_nettype wire

// File: rtl/gather_rmw_ctrl_rmw_fwd_stage.sv
// rmw_fwd_stage -- S1..S3 update registers, hazard forwarding mux and combine.
// Rev 1.0
`default_nettype none
module rmw_fwd_stage
  import gather_rmw_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int OP     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              s1_valid,
  output logic              s2_valid,
  output logic              s3_valid,
  output logic [ADDR_W-1:0] s2_addr,
  output logic [DATA_W-1:0] s2_data
);
  logic [ADDR_W-1:0] s1_addr, s3_addr;
  logic [DATA_W-1:0] s1_data, s3_data;
  logic [DATA_W-1:0] old_val, res;

  // S3 holds the write that lands on the same edge as the S1 read, so the
  // array value seen by that read is stale; S2 is newer still and wins.
  always_comb begin
    old_val = ram_dout;
    if (s3_valid && (s3_addr == s1_addr)) old_val = s3_data;
    if (s2_valid && (s2_addr == s1_addr)) old_val = s2_data;
    if (OP == OP_MIN) res = (old_val < s1_data) ? old_val : s1_data;
    else              res = old_val + s1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_addr  <= '0;
      s2_addr  <= '0;
      s3_addr  <= '0;
      s1_data  <= '0;
      s2_data  <= '0;
      s3_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_addr  <= in_addr;
      s1_data  <= in_data;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_data  <= res;
      s3_valid <= s2_valid;
      s3_addr  <= s2_addr;
      s3_data  <= s2_data;
    end
  end
endmodule
`default_nettype wire

// File: rtl/gather_rmw_ctrl.sv
// gather_rmw_ctrl -- gather-phase RMW sequencer for one URAM bank with host port and clear sweep.
// Rev 1.0
`default_nettype none
module gather_rmw_ctrl
  import gather_rmw_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int OP     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_data,
  input  logic              host_req,
  output logic              host_gnt,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_r_addr,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic              ram_w_en,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [31:0]       upd_count
);
  localparam logic [DATA_W-1:0] IDENT = DATA_W'(identity_val(OP));

  state_t            state;
  logic              host_last, rd_pend;
  logic [ADDR_W-1:0] clr_addr;
  logic [31:0]       cnt;
  logic              run, clearing, accept, host_rd, host_wr;
  logic              s1_valid, s2_valid, s3_valid;
  logic [ADDR_W-1:0] s2_addr;
  logic [DATA_W-1:0] s2_data;

  assign run      = (state == ST_RUN);
  assign clearing = (state == ST_CLEAR);
  // A granted host cycle is always followed by one update-eligible cycle.
  assign upd_ready = run & ~(host_req & ~host_last);
  assign accept    = upd_valid & upd_ready;
  assign host_gnt  = run & host_req & ~host_last & ~s1_valid & ~s2_valid;
  assign host_rd   = host_gnt & ~host_we;
  assign host_wr   = host_gnt & host_we;

  assign host_rvalid = rd_pend;
  assign host_rdata  = rd_pend ? ram_dout : '0;
  assign clr_busy    = ~run;
  assign upd_count   = cnt;

  rmw_fwd_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP(OP)) u_fwd (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(accept),
    .in_addr (upd_addr),
    .in_data (upd_data),
    .ram_dout(ram_dout),
    .s1_valid(s1_valid),
    .s2_valid(s2_valid),
    .s3_valid(s3_valid),
    .s2_addr (s2_addr),
    .s2_data (s2_data)
  );

  always_comb begin
    ram_w_addr = '0;
    ram_din    = '0;
    if (clearing) begin
      ram_w_addr = clr_addr;
      ram_din    = IDENT;
    end else if (s2_valid) begin
      ram_w_addr = s2_addr;
      ram_din    = s2_data;
    end else if (host_wr) begin
      ram_w_addr = host_addr;
      ram_din    = host_wdata;
    end
  end

  assign ram_w_en   = s2_valid | host_wr | clearing;
  assign ram_r_addr = accept ? upd_addr : (host_rd ? host_addr : '0);
  assign ram_en     = ram_w_en | accept | host_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      host_last <= 1'b0;
      rd_pend   <= 1'b0;
      clr_addr  <= '0;
      cnt       <= '0;
    end else begin
      host_last <= host_gnt;
      rd_pend   <= host_rd;
      if (accept) cnt <= cnt + 32'd1;
      case (state)
        ST_RUN:   if (clr_start) state <= ST_DRAIN;
        ST_DRAIN: if (!s1_valid && !s2_valid && !s3_valid) state <= ST_CLEAR;
        ST_CLEAR: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (&clr_addr) begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        end
        default:  state <= ST_RUN;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_gather_rmw_ctrl.sv
// tb_gather_rmw_ctrl -- add and min instances driven in lockstep, each behind its own URAM model.
// Rev 1.0
`default_nettype none
module tb_gather_rmw_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int K_UPD = 0, K_WR = 1, K_RD = 2, K_IDLE = 3, K_CLR = 4, K_CNT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          upd_valid = 1'b0, host_req = 1'b0, host_we = 1'b0, clr_start = 1'b0;
  logic [AW-1:0] upd_addr = '0, host_addr = '0;
  logic [DW-1:0] upd_data = '0, host_wdata = '0;

  logic [1:0]          upd_ready, host_gnt, host_rvalid, clr_busy, ram_en, ram_w_en;
  logic [1:0][AW-1:0]  ram_r_addr, ram_w_addr;
  logic [1:0][DW-1:0]  ram_din, host_rdata;
  logic [1:0][31:0]    upd_count;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] dout;
    always @(posedge clk) begin
      if (ram_en[g]) begin
        if (ram_w_en[g]) mem[ram_w_addr[g]] <= ram_din[g];
        dout <= mem[ram_r_addr[g]];
      end
    end
    gather_rmw_ctrl #(.DATA_W(DW), .ADDR_W(AW), .OP(g)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .upd_valid(upd_valid), .upd_ready(upd_ready[g]), .upd_addr(upd_addr), .upd_data(upd_data),
      .host_req(host_req), .host_gnt(host_gnt[g]), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_rdata(host_rdata[g]), .host_rvalid(host_rvalid[g]),
      .clr_start(clr_start), .clr_busy(clr_busy[g]),
      .ram_en(ram_en[g]), .ram_r_addr(ram_r_addr[g]), .ram_w_addr(ram_w_addr[g]),
      .ram_w_en(ram_w_en[g]), .ram_din(ram_din[g]), .ram_dout(dout), .upd_count(upd_count[g])
    );
  end

  typedef struct {
    int            kind;
    int            inst;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vt[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         output logic [DW-1:0] rd0, output logic [DW-1:0] rd1);
    bit ok = 1'b0;
    bit g;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    for (int i = 0; i < 8 && !ok; i++) begin
      #1;
      g = host_gnt[0];
      tick();
      ok = g;
    end
    host_req = 1'b0; host_we = 1'b0;
    chk("host_gnt within bound", 32'(ok), 32'd1);
    #1;
    rd0 = host_rdata[0];
    rd1 = host_rdata[1];
    if (!we) chk("host_rvalid", 32'(host_rvalid), 32'd3);
  endtask

  task automatic clear_bank(input int exp_busy);
    int n = 0;
    clr_start = 1'b1;
    #1;
    tick();
    clr_start = 1'b0;
    chk("clr_busy after start", 32'(clr_busy), 32'd3);
    while (clr_busy[0] && n < 100) begin
      n++;
      tick();
    end
    chk("clr_busy cycles", 32'(n), 32'(exp_busy));
    chk("upd_count after clear", upd_count[0] | upd_count[1], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] r0, r1;
    int acc_n, gnt_n, rv_n, viol, last, seen9;

    // Reset state
    #2;
    chk("reset upd_ready", 32'(upd_ready), 32'd3);
    chk("reset host_gnt", 32'(host_gnt), 32'd0);
    chk("reset ram_en", 32'(ram_en | ram_w_en), 32'd0);
    chk("reset clr_busy/rvalid", 32'({clr_busy, host_rvalid}), 32'd0);
    chk("reset upd_count", upd_count[0], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    vt.push_back('{K_CLR, 0, 4'd0, 32'd0, 32'd0});
    for (int i = 0; i < 4; i++) vt.push_back('{K_UPD, 0, 4'd5, 32'd1, 32'd0});
    vt.push_back('{K_UPD, 0, 4'd7, 32'd2, 32'd0});
    vt.push_back('{K_UPD, 0, 4'd8, 32'd2, 32'd0});
    vt.push_back('{K_UPD, 0, 4'd7, 32'd2, 32'd0});
    vt.push_back('{K_UPD, 0, 4'd8, 32'd2, 32'd0});
    vt.push_back('{K_UPD, 0, 4'd7, 32'd2, 32'd0});
    vt.push_back('{K_WR,  0, 4'd9, 32'd100, 32'd0});
    vt.push_back('{K_UPD, 0, 4'd9, 32'd5, 32'd0});
    vt.push_back('{K_WR,  0, 4'd10, 32'hFFFF_FFFF, 32'd0});
    vt.push_back('{K_UPD, 0, 4'd10, 32'd2, 32'd0});
    for (int i = 0; i < 3; i++) vt.push_back('{K_IDLE, 0, 4'd0, 32'd0, 32'd0});
    vt.push_back('{K_RD, 0, 4'd5, 32'd0, 32'd4});
    vt.push_back('{K_RD, 0, 4'd7, 32'd0, 32'd6});
    vt.push_back('{K_RD, 0, 4'd8, 32'd0, 32'd4});
    vt.push_back('{K_RD, 0, 4'd9, 32'd0, 32'd105});
    vt.push_back('{K_RD, 0, 4'd10, 32'd0, 32'd1});
    vt.push_back('{K_RD, 1, 4'd5, 32'd0, 32'd1});
    vt.push_back('{K_RD, 1, 4'd7, 32'd0, 32'd2});
    vt.push_back('{K_RD, 1, 4'd9, 32'd0, 32'd5});
    vt.push_back('{K_RD, 1, 4'd10, 32'd0, 32'd2});
    vt.push_back('{K_CNT, 0, 4'd0, 32'd0, 32'd11});
    vt.push_back('{K_CLR, 0, 4'd0, 32'd0, 32'd0});
    vt.push_back('{K_UPD, 0, 4'd3, 32'd9, 32'd0});
    vt.push_back('{K_UPD, 0, 4'd3, 32'd4, 32'd0});
    vt.push_back('{K_UPD, 0, 4'd3, 32'd12, 32'd0});
    vt.push_back('{K_RD, 1, 4'd3, 32'd0, 32'd4});
    vt.push_back('{K_RD, 0, 4'd3, 32'd0, 32'd25});
    vt.push_back('{K_RD, 1, 4'd4, 32'd0, 32'hFFFF_FFFF});
    vt.push_back('{K_RD, 0, 4'd4, 32'd0, 32'd0});
    vt.push_back('{K_CNT, 0, 4'd0, 32'd0, 32'd3});

    foreach (vt[i]) begin
      case (vt[i].kind)
        K_UPD: begin
          upd_valid = 1'b1; upd_addr = vt[i].addr; upd_data = vt[i].data;
          #1;
          chk($sformatf("vec%0d upd_ready", i), 32'(upd_ready), 32'd3);
          tick();
          upd_valid = 1'b0;
        end
        K_WR:  host_op(1'b1, vt[i].addr, vt[i].data, r0, r1);
        K_RD: begin
          host_op(1'b0, vt[i].addr, '0, r0, r1);
          chk($sformatf("vec%0d read inst%0d addr %0d", i, vt[i].inst, vt[i].addr),
              (vt[i].inst == 1) ? r1 : r0, vt[i].exp);
        end
        K_CLR: clear_bank(DEPTH + 1);
        K_CNT: begin
          chk($sformatf("vec%0d upd_count add", i), upd_count[0], vt[i].exp);
          chk($sformatf("vec%0d upd_count min", i), upd_count[1], vt[i].exp);
        end
        default: tick();
      endcase
    end

    // Continuous updates against a held host read request
    acc_n = 0; gnt_n = 0; rv_n = 0; viol = 0; last = 0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd12;
    upd_valid = 1'b1; upd_addr = 4'd11; upd_data = 32'd1;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (host_rvalid[0]) begin
        rv_n++;
        chk("arb host_rdata", host_rdata[0], 32'd0);
      end
      if (upd_ready[0] && host_gnt[0]) viol++;
      if (upd_ready[0]) begin
        acc_n++;
        if (last == 1) viol++;
        last = 1;
      end
      if (host_gnt[0]) begin
        gnt_n++;
        if (last == 2) viol++;
        last = 2;
      end
      tick();
    end
    upd_valid = 1'b0; host_req = 1'b0;
    chk("arb alternation violations", 32'(viol), 32'd0);
    chk("arb accepts", 32'(acc_n), 32'd6);
    chk("arb grants", 32'(gnt_n), 32'd6);
    chk("arb rvalids", 32'(rv_n), 32'd6);
    repeat (3) tick();
    host_op(1'b0, 4'd11, '0, r0, r1);
    chk("arb addr11 add", r0, 32'(acc_n));
    chk("arb addr11 min", r1, 32'd1);
    chk("arb upd_count", upd_count[0], 32'(3 + acc_n));

    // Clear issued with three updates still in flight
    upd_valid = 1'b1; upd_addr = 4'd13; upd_data = 32'd3;
    tick();
    tick();
    clr_start = 1'b1;
    #1;
    tick();
    upd_valid = 1'b0; clr_start = 1'b0;
    begin
      int n = 0;
      seen9 = 0;
      while (clr_busy[0] && n < 100) begin
        if (ram_w_en[0] && ram_w_addr[0] == 4'd13 && ram_din[0] == 32'd9) seen9++;
        n++;
        tick();
      end
      chk("inflight write completes", 32'(seen9), 32'd1);
      chk("inflight clr_busy cycles", 32'(n), 32'(DEPTH + 4));
    end
    chk("inflight upd_count", upd_count[0], 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      host_op(1'b0, AW'(a), '0, r0, r1);
      chk($sformatf("clear addr %0d add", a), r0, 32'd0);
      chk($sformatf("clear addr %0d min", a), r1, 32'hFFFF_FFFF);
    end

    // Asynchronous reset while S2 is valid
    upd_valid = 1'b1; upd_addr = 4'd2; upd_data = 32'd1;
    tick();
    tick();
    upd_valid = 1'b0;
    #1;
    chk("pre-reset S2 write", 32'(ram_w_en), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid reset ram_w_en/ram_en", 32'({ram_w_en, ram_en}), 32'd0);
    chk("mid reset upd_count", upd_count[0] | upd_count[1], 32'd0);
    chk("mid reset gnt/rvalid/busy", 32'({host_gnt, host_rvalid, clr_busy}), 32'd0);
    chk("mid reset upd_ready", 32'(upd_ready), 32'd3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("post reset upd_ready", 32'(upd_ready), 32'd3);
    chk("post reset ram_w_en", 32'(ram_w_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
